// File: rtl/multichannel_pattern_generator_pkg.sv
// Shared encodings for the multichannel pattern generator: playback modes and
// per-channel FSM states.
package multichannel_pattern_generator_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [2:0] state_t;

    localparam mode_t MODE_LOOP     = 2'd0;
    localparam mode_t MODE_ONESHOT  = 2'd1;
    localparam mode_t MODE_LOOP_GAP = 2'd2;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // The reserved encoding behaves as LOOP, so it is folded away once at config time.
    function automatic mode_t normalize_mode(input mode_t m);
        if (m == MODE_ONESHOT || m == MODE_LOOP_GAP) begin
            return m;
        end
        return MODE_LOOP;
    endfunction

endpackage

// File: rtl/multichannel_pattern_generator_channel.sv
// One pattern channel: dual-port pattern RAM, shadow/pass configuration,
// playback FSM with gap counter, and the valid pipeline that zeroes idle output.
module multichannel_pattern_generator_channel
    import multichannel_pattern_generator_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = 8,
    parameter int ADDRESS_BUS_DEPTH = 11
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         write_enable,
    input  logic [ADDRESS_BUS_DEPTH-1:0] write_address,
    input  logic [DATA_BUS_WIDTH-1:0]    data_in,
    input  logic                         config_strobe,
    input  logic [ADDRESS_BUS_DEPTH-1:0] end_read_address,
    input  logic [ADDRESS_BUS_DEPTH-1:0] gap_length,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         sync,
    output logic [DATA_BUS_WIDTH-1:0]    data_out,
    output logic                         running,
    output logic                         done
);

    localparam int WORDS = 1 << ADDRESS_BUS_DEPTH;
    localparam logic [ADDRESS_BUS_DEPTH-1:0] ADDR_ONE = ADDRESS_BUS_DEPTH'(1);

    logic [DATA_BUS_WIDTH-1:0]    pattern_mem [WORDS];
    logic [DATA_BUS_WIDTH-1:0]    read_data_reg;

    logic [ADDRESS_BUS_DEPTH-1:0] end_shadow_reg;
    logic [ADDRESS_BUS_DEPTH-1:0] gap_shadow_reg;
    mode_t                        mode_shadow_reg;

    state_t                       state_reg, state_next;
    logic [ADDRESS_BUS_DEPTH-1:0] address_reg, address_next;
    logic [ADDRESS_BUS_DEPTH-1:0] gap_count_reg, gap_count_next;
    logic [ADDRESS_BUS_DEPTH-1:0] pass_len_reg, pass_len_next;
    logic [ADDRESS_BUS_DEPTH-1:0] pass_gap_reg, pass_gap_next;
    mode_t                        pass_mode_reg, pass_mode_next;
    logic                         done_reg, done_next;
    logic                         valid_reg;
    logic [DATA_BUS_WIDTH-1:0]    data_out_reg;

    logic                         pass_start;
    logic                         end_of_pass;
    logic                         gap_last;

    // Write and read ports are independent; a same-address read sees the old word.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            pattern_mem[write_address] <= data_in;
        end
        read_data_reg <= pattern_mem[address_reg];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            end_shadow_reg  <= '0;
            gap_shadow_reg  <= '0;
            mode_shadow_reg <= MODE_LOOP;
        end else if (config_strobe) begin
            end_shadow_reg  <= end_read_address;
            gap_shadow_reg  <= gap_length;
            mode_shadow_reg <= normalize_mode(mode);
        end
    end

    // A length of 0 wraps to all-ones here, giving the full 2**depth pass.
    assign end_of_pass = (address_reg == pass_len_reg - ADDR_ONE);
    assign gap_last    = (gap_count_reg == pass_gap_reg - ADDR_ONE);

    always_comb begin
        state_next     = state_reg;
        address_next   = address_reg;
        gap_count_next = gap_count_reg;
        pass_len_next  = pass_len_reg;
        pass_gap_next  = pass_gap_reg;
        pass_mode_next = pass_mode_reg;
        done_next      = done_reg;
        pass_start     = 1'b0;

        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        done_next = 1'b0;
                        if (sync) begin
                            pass_start = 1'b1;
                        end else begin
                            state_next = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (sync) begin
                        pass_start = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (end_of_pass) begin
                        if (pass_mode_reg == MODE_ONESHOT) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else if (pass_mode_reg == MODE_LOOP_GAP && pass_gap_reg != '0) begin
                            state_next     = ST_GAP;
                            gap_count_next = '0;
                        end else begin
                            pass_start = 1'b1;
                        end
                    end else begin
                        address_next = address_reg + ADDR_ONE;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        pass_start = 1'b1;
                    end else begin
                        gap_count_next = gap_count_reg + ADDR_ONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_next = ST_ARMED;
                        done_next  = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Pass parameters are only sampled here, so config changes land on a boundary.
        if (pass_start) begin
            state_next     = ST_RUN;
            address_next   = '0;
            pass_len_next  = end_shadow_reg;
            pass_gap_next  = gap_shadow_reg;
            pass_mode_next = mode_shadow_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            address_reg   <= '0;
            gap_count_reg <= '0;
            pass_len_reg  <= '0;
            pass_gap_reg  <= '0;
            pass_mode_reg <= MODE_LOOP;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            address_reg   <= address_next;
            gap_count_reg <= gap_count_next;
            pass_len_reg  <= pass_len_next;
            pass_gap_reg  <= pass_gap_next;
            pass_mode_reg <= pass_mode_next;
            done_reg      <= done_next;
        end
    end

    // The valid bit travels with the RAM read so non-RUN addresses emit zero words.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_reg    <= 1'b0;
            data_out_reg <= '0;
        end else begin
            valid_reg    <= (state_reg == ST_RUN);
            data_out_reg <= valid_reg ? read_data_reg : '0;
        end
    end

    assign data_out = data_out_reg;
    assign running  = (state_reg == ST_RUN) || (state_reg == ST_GAP);
    assign done     = done_reg;

endmodule

// File: rtl/multichannel_pattern_generator.sv
// N-channel RAM-backed pattern generator: decodes the host channel select and
// start/stop vectors, and packs the per-channel serializer words.
module multichannel_pattern_generator
    import multichannel_pattern_generator_pkg::*;
#(
    parameter int DATA_BUS_WIDTH     = 8,
    parameter int ADDRESS_BUS_DEPTH  = 11,
    parameter int NUMBER_OF_CHANNELS = 4,
    localparam int CHANNEL_BITS      = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic [CHANNEL_BITS-1:0]                      channel,
    input  logic [ADDRESS_BUS_DEPTH-1:0]                 write_address,
    input  logic [DATA_BUS_WIDTH-1:0]                    data_in,
    input  logic                                         write_enable,
    input  logic [ADDRESS_BUS_DEPTH-1:0]                 end_read_address,
    input  logic [ADDRESS_BUS_DEPTH-1:0]                 gap_length,
    input  logic [1:0]                                   mode,
    input  logic                                         config_strobe,
    input  logic [NUMBER_OF_CHANNELS-1:0]                start,
    input  logic [NUMBER_OF_CHANNELS-1:0]                stop,
    input  logic                                         sync,
    output logic [NUMBER_OF_CHANNELS*DATA_BUS_WIDTH-1:0] data_out,
    output logic [NUMBER_OF_CHANNELS-1:0]                running,
    output logic [NUMBER_OF_CHANNELS-1:0]                done
);

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_CHANNELS; gi++) begin : g_channel
            // Out-of-range channel codes match no instance, so they are silently dropped.
            localparam logic [CHANNEL_BITS-1:0] CHANNEL_ID = CHANNEL_BITS'(gi);

            logic selected;
            assign selected = (channel == CHANNEL_ID);

            multichannel_pattern_generator_channel #(
                .DATA_BUS_WIDTH    (DATA_BUS_WIDTH),
                .ADDRESS_BUS_DEPTH (ADDRESS_BUS_DEPTH)
            ) u_channel (
                .clock            (clock),
                .reset_n          (reset_n),
                .write_enable     (write_enable && selected),
                .write_address    (write_address),
                .data_in          (data_in),
                .config_strobe    (config_strobe && selected),
                .end_read_address (end_read_address),
                .gap_length       (gap_length),
                .mode             (mode),
                .start            (start[gi]),
                .stop             (stop[gi]),
                .sync             (sync),
                .data_out         (data_out[gi*DATA_BUS_WIDTH +: DATA_BUS_WIDTH]),
                .running          (running[gi]),
                .done             (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multichannel_pattern_generator.sv
// Scoreboard bench: expected output words are queued when a channel is started
// and compared against data_out on every falling edge.
module tb_multichannel_pattern_generator;

    localparam int DW  = 8;
    localparam int AD  = 11;
    localparam int NC  = 4;
    localparam int CB  = 2;
    localparam int BUS = NC * DW;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [CB-1:0]  channel;
    logic [AD-1:0]  write_address;
    logic [DW-1:0]  data_in;
    logic           write_enable;
    logic [AD-1:0]  end_read_address;
    logic [AD-1:0]  gap_length;
    logic [1:0]     mode;
    logic           config_strobe;
    logic [NC-1:0]  start;
    logic [NC-1:0]  stop;
    logic           sync;
    logic [BUS-1:0] data_out;
    logic [NC-1:0]  running;
    logic [NC-1:0]  done;

    typedef struct packed {
        logic [BUS-1:0] mask;
        logic [BUS-1:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   bad_checks   = 0;

    multichannel_pattern_generator #(
        .DATA_BUS_WIDTH     (DW),
        .ADDRESS_BUS_DEPTH  (AD),
        .NUMBER_OF_CHANNELS (NC)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .channel          (channel),
        .write_address    (write_address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .end_read_address (end_read_address),
        .gap_length       (gap_length),
        .mode             (mode),
        .config_strobe    (config_strobe),
        .start            (start),
        .stop             (stop),
        .sync             (sync),
        .data_out         (data_out),
        .running          (running),
        .done             (done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("data_out", data_out & e.mask, e.value);
        end
    end

    function automatic logic [7:0] fill_word(input int a);
        logic [31:0] av;
        av = a;
        return av[7:0] ^ 8'h5A;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [7:0] v);
        exp_t e;
        e.mask  = 32'hFF << (ch * 8);
        e.value = 32'(v) << (ch * 8);
        exp_q.push_back(e);
    endtask

    task automatic push_zeros(input int ch, input int n);
        for (int i = 0; i < n; i++) push_exp(ch, 8'h00);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic write_word(input int ch, input int addr, input logic [7:0] v);
        channel       = CB'(ch);
        write_address = AD'(addr);
        data_in       = v;
        write_enable  = 1'b1;
        step();
        write_enable  = 1'b0;
    endtask

    task automatic config_ch(input int ch, input int len, input int gap, input logic [1:0] m);
        channel          = CB'(ch);
        end_read_address = AD'(len);
        gap_length       = AD'(gap);
        mode             = m;
        config_strobe    = 1'b1;
        step();
        config_strobe    = 1'b0;
    endtask

    task automatic stop_ch(input int ch);
        stop = NC'(1) << ch;
        step();
        stop = '0;
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; channel = '0; write_address = '0; data_in = '0; write_enable = 1'b0;
        end_read_address = '0; gap_length = '0; mode = 2'd0; config_strobe = 1'b0;
        start = '0; stop = '0; sync = 1'b0;

        repeat (3) step();
        check_val("rst_data", data_out, 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        step();

        for (int a = 0; a < 16; a++) write_word(0, a, 8'(a));
        write_word(1, 0, 8'hA0); write_word(1, 1, 8'hA1); write_word(1, 2, 8'hA2);
        write_word(1, 3, 8'hA3); write_word(1, 4, 8'hA4);
        write_word(2, 0, 8'h11); write_word(2, 1, 8'h22); write_word(2, 2, 8'h33);
        for (int a = 0; a < (1 << AD); a++) write_word(3, a, fill_word(a));
        $display("txn: pattern RAMs loaded");

        // LOOP on ch0, left running for the next tests
        config_ch(0, 16, 0, 2'd0);
        start = 4'b0001; sync = 1'b1;
        push_zeros(0, 3);
        for (int k = 0; k < 36; k++) push_exp(0, 8'(k % 16));
        step();
        start = '0; sync = 1'b0;
        $display("txn: ch0 LOOP end=16 started");
        wait_drain(100);

        // ONESHOT on ch1
        config_ch(1, 5, 0, 2'd1);
        start = 4'b0010; sync = 1'b1;
        push_zeros(1, 3);
        for (int k = 0; k < 5; k++) push_exp(1, 8'hA0 + 8'(k));
        push_zeros(1, 6);
        step();
        start = '0; sync = 1'b0;
        repeat (4) step();
        check_val("oneshot_run", {31'b0, running[1]}, 32'd1);
        check_val("oneshot_notdone", {31'b0, done[1]}, 32'd0);
        step();
        check_val("oneshot_done", {31'b0, done[1]}, 32'd1);
        check_val("oneshot_stopped", {31'b0, running[1]}, 32'd0);
        $display("txn: ch1 ONESHOT end=5 completed");
        wait_drain(100);

        // LOOP_GAP on ch2
        config_ch(2, 3, 2, 2'd2);
        start = 4'b0100; sync = 1'b1;
        push_zeros(2, 3);
        for (int r = 0; r < 3; r++) begin
            push_exp(2, 8'h11); push_exp(2, 8'h22); push_exp(2, 8'h33);
            push_zeros(2, 2);
        end
        step();
        start = '0; sync = 1'b0;
        repeat (4) step();
        check_val("gap_running", {31'b0, running[2]}, 32'd1);
        $display("txn: ch2 LOOP_GAP end=3 gap=2 started");
        wait_drain(100);
        stop_ch(2);

        // Reset while ch0 runs and ch1 holds done
        check_val("pre_rst_done", {31'b0, done[1]}, 32'd1);
        reset_n = 1'b0;
        step();
        check_val("midrst_data", data_out, 32'd0);
        check_val("midrst_running", 32'(running), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        step();
        $display("txn: reset applied mid-run");
        config_ch(0, 16, 0, 2'd0);
        start = 4'b0001; sync = 1'b1;
        push_zeros(0, 3);
        for (int k = 0; k < 20; k++) push_exp(0, 8'(k % 16));
        step();
        start = '0; sync = 1'b0;
        $display("txn: ch0 rerun after reset");
        wait_drain(100);
        stop_ch(0);

        // Arm without sync, then stop mid-run, then start+stop together on ch3
        config_ch(3, 4, 0, 2'd0);
        start = 4'b1000;
        push_zeros(3, 5);
        step();
        start = '0;
        for (int i = 0; i < 4; i++) begin
            check_val("armed_running", {31'b0, running[3]}, 32'd0);
            step();
        end
        wait_drain(10);
        sync = 1'b1;
        push_zeros(3, 3);
        for (int k = 0; k < 10; k++) push_exp(3, fill_word(k % 4));
        push_zeros(3, 4);
        step();
        sync = 1'b0;
        repeat (9) step();
        stop = 4'b1000;
        step();
        stop = '0;
        check_val("stop_running", {31'b0, running[3]}, 32'd0);
        $display("txn: ch3 armed, synced, stopped mid-run");
        wait_drain(20);
        start = 4'b1000; stop = 4'b1000; sync = 1'b1;
        push_zeros(3, 6);
        step();
        start = '0; stop = '0; sync = 1'b0;
        check_val("startstop_running", {31'b0, running[3]}, 32'd0);
        $display("txn: ch3 start+stop same cycle");
        wait_drain(20);

        // Config change mid-pass takes effect at the boundary
        config_ch(0, 8, 0, 2'd0);
        start = 4'b0001; sync = 1'b1;
        push_zeros(0, 3);
        for (int k = 0; k < 8; k++) push_exp(0, 8'(k));
        for (int k = 0; k < 12; k++) push_exp(0, 8'(k % 4));
        step();
        start = '0; sync = 1'b0;
        step();
        step();
        config_ch(0, 4, 0, 2'd0);
        $display("txn: ch0 end 8->4 mid-pass");
        wait_drain(100);
        stop_ch(0);

        // end=0 means a full 2**depth pass with natural wrap
        config_ch(3, 0, 0, 2'd0);
        start = 4'b1000; sync = 1'b1;
        push_zeros(3, 3);
        for (int k = 0; k < (1 << AD) + 4; k++) push_exp(3, fill_word(k % (1 << AD)));
        step();
        start = '0; sync = 1'b0;
        $display("txn: ch3 LOOP end=0 full-depth pass");
        wait_drain((1 << AD) + 100);
        stop_ch(3);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
